// File: rtl/mb_scan_sequencer.sv
// Raster-order macroblock sequencer: walks every MB_SIZE x MB_SIZE macroblock of a
// frame, pulsing start with the top-left (x,y) and waiting for mb_done before advancing.
module mb_scan_sequencer #(
  parameter int HEIGHT  = 352,
  parameter int WIDTH   = 288,
  parameter int MB_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        abort,
  input  logic        mb_done,
  output logic        start,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [15:0] mb_index,
  output logic        busy,
  output logic        frame_done
);

  localparam int MBS_X = WIDTH / MB_SIZE;
  localparam int MBS_Y = HEIGHT / MB_SIZE;
  localparam int TOTAL = MBS_X * MBS_Y;

  localparam logic [31:0] STEP     = 32'(MB_SIZE);
  localparam logic [31:0] X_LAST   = 32'(WIDTH - MB_SIZE);
  localparam logic [15:0] IDX_LAST = 16'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic        start_r;
  logic        busy_r;
  logic        frame_done_r;
  logic [31:0] x_r;
  logic [31:0] y_r;
  logic [15:0] idx_r;

  logic [31:0] x_nxt_s;
  logic [31:0] y_nxt_s;
  logic [15:0] idx_nxt_s;
  logic        last_s;

  // Next raster position and last-macroblock detect, derived from the held position.
  always_comb begin
    x_nxt_s   = 32'd0;
    y_nxt_s   = y_r;
    idx_nxt_s = idx_r + 16'd1;
    last_s    = (idx_r == IDX_LAST);
    if (x_r == X_LAST) begin
      x_nxt_s = 32'd0;
      y_nxt_s = y_r + STEP;
    end else begin
      x_nxt_s = x_r + STEP;
      y_nxt_s = y_r;
    end
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      x_r          <= 32'd0;
      y_r          <= 32'd0;
      idx_r        <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          frame_done_r <= 1'b0;
          if (frame_start && !abort) begin
            state_r <= ISSUE;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
            x_r     <= 32'd0;
            y_r     <= 32'd0;
            idx_r   <= 16'd0;
          end else begin
            start_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end

        // mb_done is deliberately not looked at here, even if it arrives with start.
        ISSUE: begin
          if (abort) begin
            state_r      <= IDLE;
            start_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            x_r          <= 32'd0;
            y_r          <= 32'd0;
            idx_r        <= 16'd0;
          end else begin
            state_r <= WAIT;
            start_r <= 1'b0;
          end
        end

        WAIT: begin
          if (abort) begin
            state_r      <= IDLE;
            start_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            x_r          <= 32'd0;
            y_r          <= 32'd0;
            idx_r        <= 16'd0;
          end else if (mb_done && last_s) begin
            state_r      <= DONE;
            frame_done_r <= 1'b1;
          end else if (mb_done) begin
            state_r <= ISSUE;
            start_r <= 1'b1;
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
            idx_r   <= idx_nxt_s;
          end else begin
            state_r <= WAIT;
          end
        end

        // Position registers keep the last macroblock until the next accepted frame.
        DONE: begin
          state_r      <= IDLE;
          start_r      <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
          if (abort) begin
            x_r   <= 32'd0;
            y_r   <= 32'd0;
            idx_r <= 16'd0;
          end else begin
            x_r   <= x_r;
            y_r   <= y_r;
            idx_r <= idx_r;
          end
        end

        default: begin
          state_r      <= IDLE;
          start_r      <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
          x_r          <= 32'd0;
          y_r          <= 32'd0;
          idx_r        <= 16'd0;
        end
      endcase
    end
  end

  assign start      = start_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign x          = x_r;
  assign y          = y_r;
  assign mb_index   = idx_r;

endmodule

// File: tb/tb_mb_scan_sequencer.sv
// Directed bench for mb_scan_sequencer: default 352x288 frame plus a 32x48 instance.
module tb_mb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, abort, mb_done;
  logic        start, busy, frame_done;
  logic [31:0] x, y;
  logic [15:0] mb_index;

  logic        fs2, ab2, md2;
  logic        start2, busy2, fd2;
  logic [31:0] x2, y2;
  logic [15:0] idx2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mb_scan_sequencer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort), .mb_done(mb_done),
    .start(start), .x(x), .y(y), .mb_index(mb_index), .busy(busy), .frame_done(frame_done)
  );

  mb_scan_sequencer #(.HEIGHT(32), .WIDTH(48), .MB_SIZE(16)) dut_small (
    .clk(clk), .rst(rst), .frame_start(fs2), .abort(ab2), .mb_done(md2),
    .start(start2), .x(x2), .y(y2), .mb_index(idx2), .busy(busy2), .frame_done(fd2)
  );

  // Waits (bounded) at falling edges for the next start pulse.
  task automatic wait_start(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; abort = 1'b0; mb_done = 1'b0;
    fs2 = 1'b0; ab2 = 1'b0; md2 = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (start !== 1'b0) $display("FAIL reset_start: got %0d want 0", start); else n_pass++;
    n_checks++; if (x !== 32'd0 || y !== 32'd0) $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", x, y); else n_pass++;
    n_checks++; if (mb_index !== 16'd0) $display("FAIL reset_index: got %0d want 0", mb_index); else n_pass++;
    n_checks++; if (busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL reset_busy_done: got busy=%0d fd=%0d want 0,0", busy, frame_done); else n_pass++;
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b0 || start !== 1'b0) $display("FAIL idle_after_reset: got busy=%0d start=%0d want 0,0", busy, start); else n_pass++;
  endtask

  task automatic test_full_frame();
    int ex, ey, bad_pos, bad_wait, bad_lat, starts, waited;
    bit ok, timeout;
    ex = 0; ey = 0; bad_pos = 0; bad_wait = 0; bad_lat = 0; starts = 0; timeout = 1'b0;
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    n_checks++; if (start !== 1'b1 || busy !== 1'b1) $display("FAIL fs_latency: got start=%0d busy=%0d want 1,1", start, busy); else n_pass++;
    for (int k = 0; k < 396; k++) begin
      wait_start(ok, waited);
      if (!ok) begin timeout = 1'b1; break; end
      if (waited != 0) bad_lat++;
      starts++;
      if (x !== 32'(ex) || y !== 32'(ey) || mb_index !== 16'(k)) bad_pos++;
      if (k == 0)   begin n_checks++; if (x !== 32'd0   || y !== 32'd0)   $display("FAIL mb0_xy: got (%0d,%0d) want (0,0)", x, y); else n_pass++; end
      if (k == 17)  begin n_checks++; if (x !== 32'd272 || y !== 32'd0)   $display("FAIL mb17_xy: got (%0d,%0d) want (272,0)", x, y); else n_pass++; end
      if (k == 18)  begin n_checks++; if (x !== 32'd0   || y !== 32'd16)  $display("FAIL mb18_xy: got (%0d,%0d) want (0,16)", x, y); else n_pass++; end
      if (k == 395) begin n_checks++; if (x !== 32'd272 || y !== 32'd336 || mb_index !== 16'd395) $display("FAIL mb395: got (%0d,%0d,%0d) want (272,336,395)", x, y, mb_index); else n_pass++; end
      ex += 16;
      if (ex == 288) begin ex = 0; ey += 16; end
      @(negedge clk);
      if (start !== 1'b0 || mb_index !== 16'(k)) bad_wait++;
      @(negedge clk); mb_done = 1'b1;
      @(negedge clk); mb_done = 1'b0;
    end
    n_checks++; if (timeout) $display("FAIL full_timeout: got %0d starts want 396", starts); else n_pass++;
    n_checks++; if (starts != 396) $display("FAIL full_count: got %0d want 396", starts); else n_pass++;
    n_checks++; if (bad_pos != 0) $display("FAIL full_positions: got %0d bad want 0", bad_pos); else n_pass++;
    n_checks++; if (bad_wait != 0) $display("FAIL full_wait_hold: got %0d bad want 0", bad_wait); else n_pass++;
    n_checks++; if (bad_lat != 0) $display("FAIL full_latency: got %0d late want 0", bad_lat); else n_pass++;
    n_checks++; if (frame_done !== 1'b1 || start !== 1'b0) $display("FAIL full_frame_done: got fd=%0d start=%0d want 1,0", frame_done, start); else n_pass++;
    @(negedge clk);
    n_checks++; if (frame_done !== 1'b0 || busy !== 1'b0) $display("FAIL full_end_idle: got fd=%0d busy=%0d want 0,0", frame_done, busy); else n_pass++;
    n_checks++; if (x !== 32'd272 || y !== 32'd336 || mb_index !== 16'd395) $display("FAIL full_hold_last: got (%0d,%0d,%0d) want (272,336,395)", x, y, mb_index); else n_pass++;
  endtask

  task automatic test_done_held();
    int pulses, pat_bad, fd_count, fd_cycle;
    pulses = 0; pat_bad = 0; fd_count = 0; fd_cycle = 0;
    mb_done = 1'b1;
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    for (int c = 1; c <= 800; c++) begin
      if (start === 1'b1) pulses++;
      if (start !== ((c % 2 == 1) && (c <= 791))) pat_bad++;
      if (frame_done === 1'b1) begin fd_count++; fd_cycle = c; end
      @(negedge clk);
    end
    mb_done = 1'b0;
    n_checks++; if (pulses != 396) $display("FAIL held_pulses: got %0d want 396", pulses); else n_pass++;
    n_checks++; if (pat_bad != 0) $display("FAIL held_pattern: got %0d bad cycles want 0", pat_bad); else n_pass++;
    n_checks++; if (fd_count != 1 || fd_cycle != 793) $display("FAIL held_frame_done: got count=%0d cycle=%0d want 1,793", fd_count, fd_cycle); else n_pass++;
  endtask

  task automatic test_midframe_start();
    int waited;
    bit ok;
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      wait_start(ok, waited);
      @(negedge clk); mb_done = 1'b1;
      @(negedge clk); mb_done = 1'b0;
    end
    wait_start(ok, waited);
    n_checks++; if (!ok || mb_index !== 16'd50 || x !== 32'd224 || y !== 32'd32) $display("FAIL mid_at50: got (%0d,%0d,%0d) want (224,32,50)", x, y, mb_index); else n_pass++;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    n_checks++; if (busy !== 1'b1 || start !== 1'b0 || mb_index !== 16'd50 || x !== 32'd224) $display("FAIL mid_ignored: got busy=%0d start=%0d idx=%0d x=%0d want 1,0,50,224", busy, start, mb_index, x); else n_pass++;
    mb_done = 1'b1;
    @(negedge clk); mb_done = 1'b0;
    n_checks++; if (start !== 1'b1 || mb_index !== 16'd51 || x !== 32'd240 || y !== 32'd32) $display("FAIL mid_next51: got start=%0d (%0d,%0d,%0d) want 1,(240,32,51)", start, x, y, mb_index); else n_pass++;
  endtask

  task automatic test_abort();
    int waited, stray;
    bit ok;
    stray = 0;
    for (int k = 51; k < 100; k++) begin
      @(negedge clk); mb_done = 1'b1;
      @(negedge clk); mb_done = 1'b0;
      wait_start(ok, waited);
    end
    @(negedge clk);
    n_checks++; if (mb_index !== 16'd100 || x !== 32'd160 || y !== 32'd80 || busy !== 1'b1) $display("FAIL abort_pre: got (%0d,%0d,%0d) busy=%0d want (160,80,100) 1", x, y, mb_index, busy); else n_pass++;
    mb_done = 1'b1; abort = 1'b1;
    @(negedge clk); mb_done = 1'b0; abort = 1'b0;
    n_checks++; if (start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL abort_idle: got start=%0d busy=%0d fd=%0d want 0,0,0", start, busy, frame_done); else n_pass++;
    n_checks++; if (x !== 32'd0 || y !== 32'd0 || mb_index !== 16'd0) $display("FAIL abort_clear: got (%0d,%0d,%0d) want (0,0,0)", x, y, mb_index); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (start !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_checks++; if (stray != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", stray); else n_pass++;
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    n_checks++; if (start !== 1'b1 || x !== 32'd0 || y !== 32'd0 || mb_index !== 16'd0) $display("FAIL abort_restart: got start=%0d (%0d,%0d,%0d) want 1,(0,0,0)", start, x, y, mb_index); else n_pass++;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || start !== 1'b0) $display("FAIL abort_in_issue: got busy=%0d start=%0d want 0,0", busy, start); else n_pass++;
    abort = 1'b1; frame_start = 1'b1;
    @(negedge clk); abort = 1'b0; frame_start = 1'b0;
    n_checks++; if (busy !== 1'b0 || start !== 1'b0) $display("FAIL abort_blocks_start: got busy=%0d start=%0d want 0,0", busy, start); else n_pass++;
  endtask

  task automatic test_async_reset();
    int stray;
    stray = 0;
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    @(negedge clk); mb_done = 1'b1;
    @(negedge clk); mb_done = 1'b0;
    @(negedge clk);
    n_checks++; if (x !== 32'd16 || mb_index !== 16'd1 || busy !== 1'b1) $display("FAIL arst_pre: got x=%0d idx=%0d busy=%0d want 16,1,1", x, mb_index, busy); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (x !== 32'd0 || y !== 32'd0 || mb_index !== 16'd0 || busy !== 1'b0 || start !== 1'b0 || frame_done !== 1'b0) $display("FAIL arst_immediate: got x=%0d idx=%0d busy=%0d want 0,0,0", x, mb_index, busy); else n_pass++;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (start !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_checks++; if (stray != 0) $display("FAIL arst_stays_idle: got %0d active cycles want 0", stray); else n_pass++;
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    n_checks++; if (start !== 1'b1 || x !== 32'd0 || mb_index !== 16'd0) $display("FAIL arst_restart: got start=%0d x=%0d idx=%0d want 1,0,0", start, x, mb_index); else n_pass++;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_small_frame();
    int exs[6] = '{0, 16, 32, 0, 16, 32};
    int eys[6] = '{0, 0, 0, 16, 16, 16};
    int gx[6], gy[6], gi[6];
    int n, fd_cycle;
    n = 0; fd_cycle = 0;
    md2 = 1'b1;
    fs2 = 1'b1; @(negedge clk); fs2 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (start2 === 1'b1) begin
        if (n < 6) begin gx[n] = int'(x2); gy[n] = int'(y2); gi[n] = int'(idx2); end
        n++;
      end
      if (fd2 === 1'b1) fd_cycle = c;
      @(negedge clk);
    end
    md2 = 1'b0;
    n_checks++; if (n != 6) $display("FAIL small_count: got %0d want 6", n); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        n_checks++;
        if (gx[i] != exs[i] || gy[i] != eys[i] || gi[i] != i) $display("FAIL small_mb%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, gx[i], gy[i], gi[i], exs[i], eys[i], i);
        else n_pass++;
      end
    end
    n_checks++; if (fd_cycle != 13) $display("FAIL small_frame_done: got cycle %0d want 13", fd_cycle); else n_pass++;
    n_checks++; if (busy2 !== 1'b0) $display("FAIL small_idle: got busy=%0d want 0", busy2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_done_held();
    test_midframe_start();
    test_abort();
    test_async_reset();
    test_small_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
